// File: rtl/alu_unit_if.sv
// alu_unit_if: operand/opcode/handshake bundle between the controller and alu_unit
interface alu_unit_if;
   logic [15:0] busb;
   logic [2:0]  alu_op;
   logic        start;
   logic [15:0] ac;
   logic        z;
   logic        busy;
   logic        done;
   modport master (output busb, alu_op, start, input ac, z, busy, done);
   modport slave  (input busb, alu_op, start, output ac, z, busy, done);
endinterface

// File: rtl/alu_unit.sv
// alu_unit: 16-bit accumulator ALU; serial shift-add multiplier enabled by ALU_UNIT_MUL_EN
module alu_unit (
   input  logic      i_clk,
   input  logic      i_rst_n,
   alu_unit_if.slave bus
);
   localparam logic [2:0] OP_PASS = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_CLR  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd7;
   logic [15:0] r_ac;
   logic        r_z;
   logic        r_done;
   logic [15:0] w_ac;
   logic        w_we;
   logic        w_launch;
   logic        w_last;
   logic        w_mul_op;
   logic [15:0] w_prod;
`ifdef ALU_UNIT_MUL_EN
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;
   logic [0:0]  r_state;
   logic [15:0] r_mcand;
   logic [15:0] r_mplier;
   logic [15:0] r_prod;
   logic [3:0]  r_cnt;
   assign w_launch = bus.start && (r_state == S_IDLE);
   assign w_mul_op = (bus.alu_op == OP_MUL);
   assign w_last   = (r_state == S_MUL) && (r_cnt == 4'd15);
   assign w_prod   = r_prod + (r_mplier[0] ? r_mcand : 16'h0000);
   assign bus.busy = (r_state == S_MUL);
   // multiplier sequencer: latch operands at launch, then one multiplier bit per cycle LSB-first
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_launch && w_mul_op) begin
            r_state  <= S_MUL;
            r_mcand  <= r_ac;
            r_mplier <= bus.busb;
            r_prod   <= '0;
            r_cnt    <= '0;
         end
      end else begin
         r_prod   <= w_prod;
         r_mcand  <= {r_mcand[14:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[15:1]};
         r_cnt    <= r_cnt + 4'd1;
         if (w_last) r_state <= S_IDLE;
      end
`else
   assign w_launch = bus.start;
   assign w_mul_op = 1'b0;
   assign w_last   = 1'b0;
   assign w_prod   = '0;
   assign bus.busy = 1'b0;
`endif
   // next accumulator value; opcodes without an AC write (NOP, and MUL at launch) leave w_we low
   always_comb begin
      w_ac = r_ac;
      w_we = 1'b0;
      if (w_last) begin
         w_ac = w_prod;
         w_we = 1'b1;
      end else if (w_launch) begin
         w_we = 1'b1;
         case (bus.alu_op)
            OP_PASS: w_ac = bus.busb;
            OP_ADD:  w_ac = r_ac + bus.busb;
            OP_SUB:  w_ac = r_ac - bus.busb;
            OP_INC:  w_ac = r_ac + 16'd1;
            OP_CLR:  w_ac = '0;
            OP_SHL:  w_ac = {r_ac[14:0], 1'b0};
            default: w_we = 1'b0;
         endcase
      end
   end
   // accumulator, zero flag and completion pulse
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_ac   <= '0;
         r_z    <= 1'b1;
         r_done <= 1'b0;
      end else begin
         if (w_we) begin
            r_ac <= w_ac;
            r_z  <= (w_ac == 16'h0000);
         end
         r_done <= w_last || (w_launch && !w_mul_op);
      end
   assign bus.ac   = r_ac;
   assign bus.z    = r_z;
   assign bus.done = r_done;
endmodule
